data_memory_lsu: RTL and testbench

- Byte-addressable data memory with a load/store unit, directly upstream of the writeback result mux.
- Its ReadData output is the mux's memory operand, selected when MemtoReg=1.
- Supports byte, halfword and word loads and stores, with sign or zero extension on loads.
- Detects misaligned accesses and records the first fault in sticky status registers for the control unit.

---
 rtl/mem_pkg.sv | 23 ++
 rtl/load_align.sv | 35 +++
 rtl/data_memory_lsu.sv | 132 +++++++++++++
 tb/tb_data_memory_lsu.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared access-size encodings and alignment check for the data memory path.
package mem_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;
    localparam logic [1:0] SIZE_RSVD = 2'b11;

    // True when an access of the given size cannot be served at this byte offset.
    // The reserved size is always treated as a fault.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic bad;
        bad = 1'b0;
        case (size)
            SIZE_BYTE: bad = 1'b0;
            SIZE_HALF: bad = addr_lo[0];
            SIZE_WORD: bad = (addr_lo != 2'b00);
            default:   bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/load_align.sv
// Load lane select with sign/zero extension; purely combinational so it can
// also serve the instruction-fetch byte path unchanged.
module load_align
    import mem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        is_signed,
    output logic [31:0] data
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    // Pick the addressed byte/halfword lane (little-endian) and extend it.
    always_comb begin
        data   = '0;
        byte_v = '0;
        case (addr_lo)
            2'd0:    byte_v = word[7:0];
            2'd1:    byte_v = word[15:8];
            2'd2:    byte_v = word[23:16];
            default: byte_v = word[31:24];
        endcase
        half_v = addr_lo[1] ? word[31:16] : word[15:0];
        case (size)
            SIZE_BYTE: data = {{24{is_signed & byte_v[7]}}, byte_v};
            SIZE_HALF: data = {{16{is_signed & half_v[15]}}, half_v};
            SIZE_WORD: data = word;
            default:   data = '0;
        endcase
    end

endmodule

// File: rtl/data_memory_lsu.sv
// Byte-addressable data memory with load/store unit and sticky misalignment
// status. Loads are combinational (single-cycle datapath); stores land on the edge.
module data_memory_lsu
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int ADDR_BITS   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [1:0]  MemSize,
    input  logic        MemSigned,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    input  logic        ClearFault,
    output logic [31:0] ReadData,
    output logic        MisalignFault,
    output logic [31:0] FaultAddr,
    output logic        FaultIsStore
);

    // Array contents are deliberately never reset; they survive a reset pulse.
    logic [31:0] mem [DEPTH_WORDS];

    logic [ADDR_BITS-1:0] word_idx;
    logic                 misaligned;
    logic                 fault_now;
    logic                 store_en;
    logic [3:0]           byte_en;
    logic [31:0]          wdata_lanes;
    logic [31:0]          raw_word;
    logic [31:0]          aligned_data;

    logic        fault_d,   fault_q;
    logic [31:0] faddr_d,   faddr_q;
    logic        fis_d,     fis_q;

    // Upper address bits fall away here, so the array aliases modulo its size.
    assign word_idx   = Address[ADDR_BITS+1:2];
    assign misaligned = is_misaligned(MemSize, Address[1:0]);
    assign fault_now  = (MemRead | MemWrite) & misaligned;
    assign store_en   = MemWrite & ~misaligned;
    assign raw_word   = mem[word_idx];

    load_align u_load_align (
        .word      (raw_word),
        .addr_lo   (Address[1:0]),
        .size      (MemSize),
        .is_signed (MemSigned),
        .data      (aligned_data)
    );

    // Load result is forced to zero when no load is active or it is misaligned.
    always_comb begin
        ReadData = '0;
        if (MemRead && !misaligned) begin
            ReadData = aligned_data;
        end
    end

    // Byte enables and replicated store data so each lane sees its own bits.
    always_comb begin
        byte_en     = 4'b0000;
        wdata_lanes = WriteData;
        case (MemSize)
            SIZE_BYTE: begin
                byte_en     = 4'b0001 << Address[1:0];
                wdata_lanes = {4{WriteData[7:0]}};
            end
            SIZE_HALF: begin
                byte_en     = Address[1] ? 4'b1100 : 4'b0011;
                wdata_lanes = {2{WriteData[15:0]}};
            end
            SIZE_WORD: begin
                byte_en     = 4'b1111;
                wdata_lanes = WriteData;
            end
            default: begin
                byte_en     = 4'b0000;
                wdata_lanes = WriteData;
            end
        endcase
    end

    // Lane-masked store; nothing is written while reset is held.
    always_ff @(posedge clk) begin
        if (!reset && store_en) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i]) begin
                    mem[word_idx][8*i +: 8] <= wdata_lanes[8*i +: 8];
                end
            end
        end
    end

    // First fault wins, except that a fault arriving with ClearFault replaces
    // the old record (set beats clear); a lone clear wipes the record.
    always_comb begin
        fault_d = fault_q;
        faddr_d = faddr_q;
        fis_d   = fis_q;
        if (fault_now && (!fault_q || ClearFault)) begin
            fault_d = 1'b1;
            faddr_d = Address;
            fis_d   = MemWrite;
        end else if (ClearFault && !fault_now) begin
            fault_d = 1'b0;
            faddr_d = '0;
            fis_d   = 1'b0;
        end
    end

    // Sticky status registers, cleared asynchronously by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fault_q <= 1'b0;
            faddr_q <= '0;
            fis_q   <= 1'b0;
        end else begin
            fault_q <= fault_d;
            faddr_q <= faddr_d;
            fis_q   <= fis_d;
        end
    end

    assign MisalignFault = fault_q;
    assign FaultAddr     = faddr_q;
    assign FaultIsStore  = fis_q;

endmodule

// File: tb/tb_data_memory_lsu.sv
// Table-driven bench for data_memory_lsu with a scoreboard queue of expected results.
module tb_data_memory_lsu;

    localparam int DEPTH_WORDS = 256;
    localparam int ADDR_BITS   = 8;

    logic        clk;
    logic        reset;
    logic        MemRead;
    logic        MemWrite;
    logic [1:0]  MemSize;
    logic        MemSigned;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic        ClearFault;
    logic [31:0] ReadData;
    logic        MisalignFault;
    logic [31:0] FaultAddr;
    logic        FaultIsStore;

    int checks = 0;
    int errors = 0;

    data_memory_lsu #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .ADDR_BITS   (ADDR_BITS)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .MemRead       (MemRead),
        .MemWrite      (MemWrite),
        .MemSize       (MemSize),
        .MemSigned     (MemSigned),
        .Address       (Address),
        .WriteData     (WriteData),
        .ClearFault    (ClearFault),
        .ReadData      (ReadData),
        .MisalignFault (MisalignFault),
        .FaultAddr     (FaultAddr),
        .FaultIsStore  (FaultIsStore)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        rd;
        logic        wr;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        clr;
        logic [31:0] exp_rdata;
        logic        exp_fault;
        logic [31:0] exp_faddr;
        logic        exp_fis;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic add(input string name, input logic rd, input logic wr, input logic [1:0] size,
                       input logic sgn, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic clr, input logic [31:0] er, input logic ef,
                       input logic [31:0] efa, input logic efs);
        vec_t v;
        v.name = name; v.rd = rd; v.wr = wr; v.size = size; v.sgn = sgn;
        v.addr = addr; v.wdata = wdata; v.clr = clr; v.exp_rdata = er;
        v.exp_fault = ef; v.exp_faddr = efa; v.exp_fis = efs;
        vecs.push_back(v);
    endtask

    task automatic idle();
        MemRead = 0; MemWrite = 0; MemSize = 2'b10; MemSigned = 0;
        Address = 0; WriteData = 0; ClearFault = 0;
    endtask

    // Called at posedge+1: drive, check combinational load mid-cycle, check status after the edge.
    task automatic run_vec(input vec_t v);
        vec_t e;
        MemRead = v.rd; MemWrite = v.wr; MemSize = v.size; MemSigned = v.sgn;
        Address = v.addr; WriteData = v.wdata; ClearFault = v.clr;
        sb.push_back(v);
        @(negedge clk);
        e = sb.pop_front();
        check32({e.name, ".rdata"}, ReadData, e.exp_rdata);
        @(posedge clk);
        #1;
        check32({e.name, ".fault"}, {31'd0, MisalignFault}, {31'd0, e.exp_fault});
        check32({e.name, ".faddr"}, FaultAddr, e.exp_faddr);
        check32({e.name, ".fis"},   {31'd0, FaultIsStore}, {31'd0, e.exp_fis});
        $display("txn %-8s rd=%0b wr=%0b sz=%0d addr=0x%08h rdata=0x%08h flt=%0b fa=0x%08h fs=%0b",
                 e.name, e.rd, e.wr, e.size, e.addr, ReadData, MisalignFault, FaultAddr, FaultIsStore);
        idle();
    endtask

    initial begin
        //    name       rd wr size   sg addr          wdata         clr exp_rdata     flt faddr         fis
        add("sw10",     0, 1, 2'b10, 0, 32'h10,       32'hDEADBEEF, 0, 32'h0,        0, 32'h0,        0);
        add("lw10",     1, 0, 2'b10, 0, 32'h10,       32'h0,        0, 32'hDEADBEEF, 0, 32'h0,        0);
        add("sw20",     0, 1, 2'b10, 0, 32'h20,       32'h80FF7F01, 0, 32'h0,        0, 32'h0,        0);
        add("lb23",     1, 0, 2'b00, 1, 32'h23,       32'h0,        0, 32'hFFFFFF80, 0, 32'h0,        0);
        add("lbu23",    1, 0, 2'b00, 0, 32'h23,       32'h0,        0, 32'h00000080, 0, 32'h0,        0);
        add("lb20",     1, 0, 2'b00, 1, 32'h20,       32'h0,        0, 32'h00000001, 0, 32'h0,        0);
        add("lb21",     1, 0, 2'b00, 1, 32'h21,       32'h0,        0, 32'h0000007F, 0, 32'h0,        0);
        add("lh22",     1, 0, 2'b01, 1, 32'h22,       32'h0,        0, 32'hFFFF80FF, 0, 32'h0,        0);
        add("lhu22",    1, 0, 2'b01, 0, 32'h22,       32'h0,        0, 32'h000080FF, 0, 32'h0,        0);
        add("lws20",    1, 0, 2'b10, 1, 32'h20,       32'h0,        0, 32'h80FF7F01, 0, 32'h0,        0);
        add("sw30",     0, 1, 2'b10, 0, 32'h30,       32'h11223344, 0, 32'h0,        0, 32'h0,        0);
        add("sb31",     0, 1, 2'b00, 0, 32'h31,       32'hFFFFFFAA, 0, 32'h0,        0, 32'h0,        0);
        add("lw30a",    1, 0, 2'b10, 0, 32'h30,       32'h0,        0, 32'h1122AA44, 0, 32'h0,        0);
        add("sh32",     0, 1, 2'b01, 0, 32'h32,       32'h1234BEEF, 0, 32'h0,        0, 32'h0,        0);
        add("lw30b",    1, 0, 2'b10, 0, 32'h30,       32'h0,        0, 32'hBEEFAA44, 0, 32'h0,        0);
        add("sw40",     0, 1, 2'b10, 0, 32'h40,       32'hCAFEF00D, 0, 32'h0,        0, 32'h0,        0);
        add("sw41",     0, 1, 2'b10, 0, 32'h41,       32'h55555555, 0, 32'h0,        1, 32'h41,       1);
        add("lw40",     1, 0, 2'b10, 0, 32'h40,       32'h0,        0, 32'hCAFEF00D, 1, 32'h41,       1);
        add("lh43",     1, 0, 2'b01, 1, 32'h43,       32'h0,        0, 32'h0,        1, 32'h41,       1);
        add("clrlw46",  1, 0, 2'b10, 0, 32'h46,       32'h0,        1, 32'h0,        1, 32'h46,       0);
        add("clr",      0, 0, 2'b10, 0, 32'h0,        32'h0,        1, 32'h0,        0, 32'h0,        0);
        add("noread",   0, 0, 2'b10, 0, 32'h40,       32'h0,        0, 32'h0,        0, 32'h0,        0);
        add("rsvd44",   1, 0, 2'b11, 0, 32'h44,       32'h0,        0, 32'h0,        1, 32'h44,       0);
        add("clr2",     0, 0, 2'b10, 0, 32'h0,        32'h0,        1, 32'h0,        0, 32'h0,        0);
        add("rdwr40",   1, 1, 2'b10, 0, 32'h40,       32'h01020304, 0, 32'hCAFEF00D, 0, 32'h0,        0);
        add("lw40b",    1, 0, 2'b10, 0, 32'h40,       32'h0,        0, 32'h01020304, 0, 32'h0,        0);
        add("swwrap",   0, 1, 2'b10, 0, DEPTH_WORDS*4+32'h8, 32'h12345678, 0, 32'h0, 0, 32'h0,      0);
        add("lw8",      1, 0, 2'b10, 0, 32'h8,        32'h0,        0, 32'h12345678, 0, 32'h0,        0);
        add("swC",      0, 1, 2'b10, 0, 32'hC,        32'hAABBCCDD, 0, 32'h0,        0, 32'h0,        0);
        add("lh1flt",   1, 0, 2'b01, 0, 32'h1,        32'h0,        0, 32'h0,        1, 32'h1,        0);

        idle();
        reset = 1'b1;
        #1;
        check32("rst.fault", {31'd0, MisalignFault}, 32'd0);
        check32("rst.faddr", FaultAddr, 32'd0);
        check32("rst.fis",   {31'd0, FaultIsStore}, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;

        foreach (vecs[i]) run_vec(vecs[i]);

        // Reset mid-cycle while a store to 0xC is pending: status clears at once, no write.
        MemWrite = 1; MemSize = 2'b10; Address = 32'hC; WriteData = 32'h99999999;
        #2;
        reset = 1'b1;
        #1;
        check32("midrst.fault", {31'd0, MisalignFault}, 32'd0);
        check32("midrst.faddr", FaultAddr, 32'd0);
        check32("midrst.fis",   {31'd0, FaultIsStore}, 32'd0);
        $display("txn midrst   flt=%0b fa=0x%08h fs=%0b", MisalignFault, FaultAddr, FaultIsStore);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        idle();
        @(posedge clk);
        #1;
        vecs.delete();
        add("lwCpost",  1, 0, 2'b10, 0, 32'hC,        32'h0,        0, 32'hAABBCCDD, 0, 32'h0,        0);
        add("lw8post",  1, 0, 2'b10, 0, 32'h8,        32'h0,        0, 32'h12345678, 0, 32'h0,        0);
        add("lw408",    1, 0, 2'b10, 0, DEPTH_WORDS*4+32'h8, 32'h0, 0, 32'h12345678, 0, 32'h0,        0);
        foreach (vecs[i]) run_vec(vecs[i]);

        check32("sb.empty", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
